alu_reg_exec: RTL and testbench
===============================

// Module: alu_reg_exec
// PURPOSE
//   Multi-cycle execute unit for RV32 R-type (OP, opcode 0110011) instructions.
//   Accepts one instruction per valid/ready handshake and reads rs1/rs2 from the register file.
//   Drives the shared ALU, then presents rd/result on a valid/ready writeback port.
//   Sits between the fetch/dispatch logic and the register-file write port; replaces the old enable_n/hi-Z scheme.
// PARAMETERS
//   XLEN            32  datapath width (32 or 64)
//   REG_SELECT_LEN  5   register index width
//   RF_READ_LAT     1   register-file read latency in cycles (1..3)
// PORTS
//   clk              in   1               clock, all state on posedge
//   rst_n            in   1               asynchronous active-low reset
//   instr_valid      in   1               instruction offered
//   instr_ready      out  1               unit can accept instruction this cycle
//   instruction      in   32              RISC-V instruction word
//   illegal          out  1               1-cycle pulse: offered instruction rejected
//   rf_rd_en         out  1               register-file read strobe
//   rf_rd_addr_1     out  REG_SELECT_LEN  rs1 = instruction[19:15]
//   rf_rd_addr_2     out  REG_SELECT_LEN  rs2 = instruction[24:20]
//   rf_rd_data_1     in   XLEN            rs1 data, valid RF_READ_LAT cycles after rf_rd_en
//   rf_rd_data_2     in   XLEN            rs2 data, same timing
//   alu_a, alu_b     out  XLEN            ALU operands
//   alu_op           out  3               funct3 = instruction[14:12]
//   alu_sig          out  1               instruction[30] (SUB/SRA select)
//   alu_out          in   XLEN            combinational ALU result
//   wb_valid         out  1               writeback offered
//   wb_ready         in   1               register file accepts writeback
//   wb_reg           out  REG_SELECT_LEN  rd = instruction[11:7]
//   wb_data          out  XLEN            result
//   busy             out  1               state != IDLE
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; all outputs 0, except instr_ready=1. Outputs are never hi-Z.
//   - FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
//   - IDLE: instr_ready=1. On instr_valid, latch instruction and decode it.
//   - Illegal when opcode != 0110011, funct7 not in {0000000, 0100000}, or funct7=0100000 with funct3 not in {000, 101}.
//   - Illegal instruction: illegal=1 for one cycle; stay IDLE; nothing written back.
//   - READ: rf_rd_en=1 on the first cycle only; addresses held stable for the whole state.
//   - READ: a down-counter waits RF_READ_LAT cycles, then rf_rd_data_* are latched into operand registers -> EXEC.
//   - EXEC (1 cycle): alu_a/alu_b/alu_op/alu_sig driven from latched regs; alu_out captured into result reg -> WB.
//   - alu_a/alu_b/alu_op/alu_sig are 0 outside EXEC.
//   - WB: wb_valid=1; wb_reg/wb_data held stable until wb_ready. Handshake cycle -> IDLE.
//   - rd=x0 skips WB (EXEC -> IDLE); wb_valid is never asserted for rd=0.
//   - Latency: accept cycle T -> wb_valid first high at T+RF_READ_LAT+2.
//   - Result width is exactly XLEN; overflow wraps; no flags.
//   - instr_valid outside an instr_ready cycle is ignored; the instruction is not latched.
// CONFIGURATION
//   ALU_REG_BYPASS_EN defined:
//     - In WB, instr_ready = wb_ready, so a new instruction is accepted in the writeback handshake cycle.
//     - That instruction goes directly to READ, giving back-to-back throughput.
//     - Last-written rd/result are kept. At operand latch, rs1/rs2 equal to that nonzero rd take the kept result instead of rf_rd_data.
//   ALU_REG_BYPASS_EN undefined:
//     - instr_ready only in IDLE; no forwarding.
//     - Minimum issue interval is RF_READ_LAT+3 cycles.
// STRUCTURE
//   - Package alu_reg_pkg:
//     - state_t enum {IDLE, READ, EXEC, WB}
//     - OPC_OP=7'b0110011
//     - FUNCT7_BASE, FUNCT7_ALT
//     - funct3 localparams (ADD, SLL, SLT, SLTU, XOR, SR, OR, AND)
//     - decoded-fields struct {rs1, rs2, rd, funct3, alt, legal}
//   - Sub-module alu_reg_decode: combinational field extraction and legality check, returns the struct.
// TESTING
//   - add x3,x1,x2 (0x002081B3), RF x1=5, x2=7, ALU model, wb_ready=1 -> wb_valid at T+3 (LAT=1), wb_reg=3, wb_data=12.
//   - sub x4,x1,x2 with x1=1, x2=2 -> alu_sig=1, alu_op=000, wb_data=0xFFFFFFFF.
//   - Opcode 0010011 offered -> illegal pulses 1 cycle, instr_ready stays 1, no wb_valid.
//   - Any instruction with rd=0 -> no wb_valid, busy drops after EXEC.
//   - wb_ready held 0 for 5 cycles -> wb_valid/wb_reg/wb_data stable, instr_ready=0; release -> back to IDLE.
//   - With ALU_REG_BYPASS_EN: add x5,x1,x2 then add x6,x5,x5 back-to-back with RF returning stale x5=0.
//     -> 2nd instruction accepted in 1st WB cycle; wb_data=2*(x1+x2).
//   - Assert rst_n low mid-READ -> all outputs 0, instr_ready=1 next edge.

Source files
------------

// File: rtl/alu_reg_pkg.sv
// Shared types and encodings for the RV32 R-type execute unit.
package alu_reg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] funct3;
        logic       alt;
        logic       legal;
    } dec_t;

endpackage

// File: rtl/alu_reg_decode.sv
// Field extraction and legality check for OP-class instructions.
module alu_reg_decode
    import alu_reg_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0] funct7;
    logic [2:0] funct3;

    assign funct7 = instr_i[31:25];
    assign funct3 = instr_i[14:12];

    always_comb begin
        dec_o        = '0;
        dec_o.rs1    = instr_i[19:15];
        dec_o.rs2    = instr_i[24:20];
        dec_o.rd     = instr_i[11:7];
        dec_o.funct3 = funct3;
        dec_o.alt    = instr_i[30];
        // The alternate funct7 only encodes SUB and SRA.
        dec_o.legal  = (instr_i[6:0] == OPC_OP) &&
                       ((funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))));
    end

endmodule

// File: rtl/alu_reg_exec.sv
// Multi-cycle R-type execute unit: IDLE -> READ -> EXEC -> WB.
// Define ALU_REG_BYPASS_EN for issue in the writeback cycle plus result forwarding.
module alu_reg_exec
    import alu_reg_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int REG_SELECT_LEN = 5,
    parameter int RF_READ_LAT    = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [31:0]               instruction,
    output logic                      illegal,
    output logic                      rf_rd_en,
    output logic [REG_SELECT_LEN-1:0] rf_rd_addr_1,
    output logic [REG_SELECT_LEN-1:0] rf_rd_addr_2,
    input  logic [XLEN-1:0]           rf_rd_data_1,
    input  logic [XLEN-1:0]           rf_rd_data_2,
    output logic [XLEN-1:0]           alu_a,
    output logic [XLEN-1:0]           alu_b,
    output logic [2:0]                alu_op,
    output logic                      alu_sig,
    input  logic [XLEN-1:0]           alu_out,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [REG_SELECT_LEN-1:0] wb_reg,
    output logic [XLEN-1:0]           wb_data,
    output logic                      busy
);

    localparam logic [1:0] CNT_INIT = 2'(RF_READ_LAT - 1);

    dec_t            dec;
    state_t          state_q, state_d;
    logic [4:0]      rs1_q, rs2_q, rd_q;
    logic [2:0]      f3_q;
    logic            alt_q, first_q, illegal_q;
    logic [1:0]      cnt_q;
    logic [XLEN-1:0] opa_q, opb_q, res_q;
    logic [XLEN-1:0] rs1_val, rs2_val;
    logic            accept;

    alu_reg_decode u_decode (
        .instr_i (instruction),
        .dec_o   (dec)
    );

`ifdef ALU_REG_BYPASS_EN
    logic [4:0]      fwd_rd_q;
    logic [XLEN-1:0] fwd_val_q;

    assign instr_ready = (state_q == IDLE) || ((state_q == WB) && wb_ready);
    assign rs1_val = ((fwd_rd_q != 5'd0) && (rs1_q == fwd_rd_q)) ? fwd_val_q : rf_rd_data_1;
    assign rs2_val = ((fwd_rd_q != 5'd0) && (rs2_q == fwd_rd_q)) ? fwd_val_q : rf_rd_data_2;

    // Remember the most recent retired write so a dependent follower skips stale RF data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_rd_q  <= '0;
            fwd_val_q <= '0;
        end else if ((state_q == WB) && wb_ready) begin
            fwd_rd_q  <= rd_q;
            fwd_val_q <= res_q;
        end
    end
`else
    assign instr_ready = (state_q == IDLE);
    assign rs1_val     = rf_rd_data_1;
    assign rs2_val     = rf_rd_data_2;
`endif

    assign accept = instr_valid && instr_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && dec.legal) state_d = READ;
            READ: if (cnt_q == 2'd0) state_d = EXEC;
            EXEC: state_d = (rd_q == 5'd0) ? IDLE : WB;
            WB:   if (wb_ready) state_d = (accept && dec.legal) ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            f3_q      <= '0;
            alt_q     <= 1'b0;
            first_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= accept && !dec.legal;
            if (accept && dec.legal) begin
                rs1_q   <= dec.rs1;
                rs2_q   <= dec.rs2;
                rd_q    <= dec.rd;
                f3_q    <= dec.funct3;
                alt_q   <= dec.alt;
                cnt_q   <= CNT_INIT;
                first_q <= 1'b1;
            end
            if (state_q == READ) begin
                first_q <= 1'b0;
                if (cnt_q != 2'd0) begin
                    cnt_q <= cnt_q - 2'd1;
                end else begin
                    opa_q <= rs1_val;
                    opb_q <= rs2_val;
                end
            end
            if (state_q == EXEC) res_q <= alu_out;
        end
    end

    // Every output is gated by state so idle and reset both present zeros.
    assign illegal      = illegal_q;
    assign busy         = (state_q != IDLE);
    assign rf_rd_en     = (state_q == READ) && first_q;
    assign rf_rd_addr_1 = (state_q == READ) ? REG_SELECT_LEN'(rs1_q) : '0;
    assign rf_rd_addr_2 = (state_q == READ) ? REG_SELECT_LEN'(rs2_q) : '0;
    assign alu_a        = (state_q == EXEC) ? opa_q : '0;
    assign alu_b        = (state_q == EXEC) ? opb_q : '0;
    assign alu_op       = (state_q == EXEC) ? f3_q : '0;
    assign alu_sig      = (state_q == EXEC) && alt_q;
    assign wb_valid     = (state_q == WB);
    assign wb_reg       = (state_q == WB) ? REG_SELECT_LEN'(rd_q) : '0;
    assign wb_data      = (state_q == WB) ? res_q : '0;

endmodule

// File: tb/tb_alu_reg_exec.sv
// Directed bench for alu_reg_exec with a combinational RF and ALU model (RF_READ_LAT=1).
module tb_alu_reg_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic        illegal;
    logic        rf_rd_en;
    logic [4:0]  rf_rd_addr_1, rf_rd_addr_2;
    logic [31:0] rf_rd_data_1, rf_rd_data_2;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_op;
    logic        alu_sig;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        busy;

    logic [31:0] rf [32];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    alu_reg_exec #(.XLEN(32), .REG_SELECT_LEN(5), .RF_READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instruction(instruction), .illegal(illegal), .rf_rd_en(rf_rd_en),
        .rf_rd_addr_1(rf_rd_addr_1), .rf_rd_addr_2(rf_rd_addr_2),
        .rf_rd_data_1(rf_rd_data_1), .rf_rd_data_2(rf_rd_data_2),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sig(alu_sig), .alu_out(alu_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg), .wb_data(wb_data), .busy(busy)
    );

    assign rf_rd_data_1 = rf[rf_rd_addr_1];
    assign rf_rd_data_2 = rf[rf_rd_addr_2];

    always_comb begin
        case (alu_op)
            3'b000:  alu_out = alu_sig ? alu_a - alu_b : alu_a + alu_b;
            3'b001:  alu_out = alu_a << alu_b[4:0];
            3'b010:  alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            3'b011:  alu_out = {31'b0, alu_a < alu_b};
            3'b100:  alu_out = alu_a ^ alu_b;
            3'b101:  alu_out = alu_sig ? 32'($signed(alu_a) >>> alu_b[4:0]) : alu_a >> alu_b[4:0];
            3'b110:  alu_out = alu_a | alu_b;
            default: alu_out = alu_a & alu_b;
        endcase
    end

    // Called on a negedge; returns on the negedge of the cycle after acceptance.
    task automatic issue(input logic [31:0] w);
        instr_valid = 1'b1;
        instruction = w;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({instr_ready, illegal, rf_rd_en, wb_valid, busy} !== 5'b10000) begin
            $display("FAIL reset_ctrl got=%b want=10000", {instr_ready, illegal, rf_rd_en, wb_valid, busy});
        end else passed++;
        total++;
        if ((|{rf_rd_addr_1, rf_rd_addr_2, alu_a, alu_b, alu_op, alu_sig, wb_reg, wb_data}) !== 1'b0) begin
            $display("FAIL reset_data got=nonzero want=0");
        end else passed++;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        sig;
        logic [31:0] res;
    } vec_t;

    task automatic test_ops();
        vec_t v[7];
        v[0] = '{32'h002081B3, 32'd5,         32'd7, 5'd3, 1'b0, 32'd12};
        v[1] = '{32'h40208233, 32'd1,         32'd2, 5'd4, 1'b1, 32'hFFFFFFFF};
        v[2] = '{32'h002081B3, 32'hFFFFFFFF,  32'd2, 5'd3, 1'b0, 32'd1};
        v[3] = '{32'h4020D3B3, 32'h80000000,  32'd4, 5'd7, 1'b1, 32'hF8000000};
        v[4] = '{32'h0020D3B3, 32'h80000000,  32'd4, 5'd7, 1'b0, 32'h08000000};
        v[5] = '{32'h0020A433, 32'hFFFFFFFF,  32'd1, 5'd8, 1'b0, 32'd1};
        v[6] = '{32'h0020B433, 32'hFFFFFFFF,  32'd1, 5'd8, 1'b0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            rf[1] = v[i].a;
            rf[2] = v[i].b;
            issue(v[i].ins);
            total++;
            if ({busy, rf_rd_en, rf_rd_addr_1, rf_rd_addr_2, wb_valid, instr_ready} !== {2'b11, 5'd1, 5'd2, 2'b00}) begin
                $display("FAIL op%0d_read got=%b", i, {busy, rf_rd_en, rf_rd_addr_1, rf_rd_addr_2, wb_valid, instr_ready});
            end else passed++;
            @(negedge clk);
            total++;
            if ({alu_a, alu_b, alu_sig, rf_rd_en} !== {v[i].a, v[i].b, v[i].sig, 1'b0}) begin
                $display("FAIL op%0d_exec got a=%h b=%h sig=%b want a=%h b=%h sig=%b",
                         i, alu_a, alu_b, alu_sig, v[i].a, v[i].b, v[i].sig);
            end else passed++;
            @(negedge clk);
            total++;
            if ({wb_valid, wb_reg, wb_data} !== {1'b1, v[i].rd, v[i].res}) begin
                $display("FAIL op%0d_wb got v=%b rd=%0d d=%h want rd=%0d d=%h",
                         i, wb_valid, wb_reg, wb_data, v[i].rd, v[i].res);
            end else passed++;
            @(negedge clk);
            total++;
            if ({busy, wb_valid, instr_ready} !== 3'b001) begin
                $display("FAIL op%0d_idle got=%b want=001", i, {busy, wb_valid, instr_ready});
            end else passed++;
        end
        total++;
        if (alu_op !== 3'b000) $display("FAIL alu_op_idle got=%b want=000", alu_op);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [31:0] bad [3];
        int wb_seen;
        bad[0] = 32'h00208193;
        bad[1] = 32'h40209233;
        bad[2] = 32'h022081B3;
        for (int i = 0; i < 3; i++) begin
            issue(bad[i]);
            total++;
            if ({illegal, instr_ready, busy} !== 3'b110) begin
                $display("FAIL illegal%0d_pulse got=%b want=110", i, {illegal, instr_ready, busy});
            end else passed++;
            wb_seen = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (wb_valid || busy || illegal) wb_seen++;
            end
            total++;
            if (wb_seen !== 0) $display("FAIL illegal%0d_after got=%0d want=0", i, wb_seen);
            else passed++;
        end
    endtask

    task automatic test_rd_zero();
        int wb_seen = 0;
        rf[1] = 32'd9;
        rf[2] = 32'd1;
        issue(32'h00208033);
        if (wb_valid) wb_seen++;
        @(negedge clk);
        total++;
        if (busy !== 1'b1) $display("FAIL rd0_exec_busy got=%b want=1", busy);
        else passed++;
        if (wb_valid) wb_seen++;
        @(negedge clk);
        total++;
        if ({busy, wb_valid, instr_ready} !== 3'b001) begin
            $display("FAIL rd0_idle got=%b want=001", {busy, wb_valid, instr_ready});
        end else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (wb_valid) wb_seen++;
        end
        total++;
        if (wb_seen !== 0) $display("FAIL rd0_no_wb got=%0d want=0", wb_seen);
        else passed++;
    endtask

    task automatic test_stall();
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        wb_ready = 1'b0;
        issue(32'h002081B3);
        @(negedge clk);
        @(negedge clk);
        // A new offer while stalled must be ignored.
        instr_valid = 1'b1;
        instruction = 32'h002084B3;
        for (int c = 0; c < 5; c++) begin
            total++;
            if ({wb_valid, wb_reg, wb_data, instr_ready} !== {1'b1, 5'd3, 32'd12, 1'b0}) begin
                $display("FAIL stall%0d got v=%b rd=%0d d=%h rdy=%b want v=1 rd=3 d=c rdy=0",
                         c, wb_valid, wb_reg, wb_data, instr_ready);
            end else passed++;
            @(negedge clk);
        end
        instr_valid = 1'b0;
        wb_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, wb_valid, instr_ready} !== 3'b001) begin
            $display("FAIL stall_release got=%b want=001", {busy, wb_valid, instr_ready});
        end else passed++;
    endtask

    task automatic test_back_to_back();
        rf[1] = 32'd3;
        rf[2] = 32'd4;
        rf[5] = 32'd0;
`ifdef ALU_REG_BYPASS_EN
        issue(32'h002082B3);
        @(negedge clk);
        @(negedge clk);
        instr_valid = 1'b1;
        instruction = 32'h00528333;
        total++;
        if ({wb_valid, wb_data, instr_ready} !== {1'b1, 32'd7, 1'b1}) begin
            $display("FAIL b2b_first_wb got v=%b d=%h rdy=%b want v=1 d=7 rdy=1", wb_valid, wb_data, instr_ready);
        end else passed++;
        @(negedge clk);
        instr_valid = 1'b0;
        total++;
        if ({busy, rf_rd_en, wb_valid} !== 3'b110) begin
            $display("FAIL b2b_read got=%b want=110", {busy, rf_rd_en, wb_valid});
        end else passed++;
        @(negedge clk);
        total++;
        if ({alu_a, alu_b} !== {32'd7, 32'd7}) begin
            $display("FAIL b2b_fwd got a=%h b=%h want a=7 b=7", alu_a, alu_b);
        end else passed++;
        @(negedge clk);
        total++;
        if ({wb_valid, wb_reg, wb_data} !== {1'b1, 5'd6, 32'd14}) begin
            $display("FAIL b2b_second_wb got v=%b rd=%0d d=%h want rd=6 d=e", wb_valid, wb_reg, wb_data);
        end else passed++;
        @(negedge clk);
`else
        issue(32'h002082B3);
        instr_valid = 1'b1;
        instruction = 32'h00528333;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({wb_valid, wb_data, instr_ready} !== {1'b1, 32'd7, 1'b0}) begin
            $display("FAIL b2b_first_wb got v=%b d=%h rdy=%b want v=1 d=7 rdy=0", wb_valid, wb_data, instr_ready);
        end else passed++;
        @(negedge clk);
        total++;
        if ({busy, instr_ready} !== 2'b01) $display("FAIL b2b_idle got=%b want=01", {busy, instr_ready});
        else passed++;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({wb_valid, wb_reg, wb_data} !== {1'b1, 5'd6, 32'd0}) begin
            $display("FAIL b2b_no_fwd got v=%b rd=%0d d=%h want rd=6 d=0", wb_valid, wb_reg, wb_data);
        end else passed++;
        @(negedge clk);
`endif
        total++;
        if (busy !== 1'b0) $display("FAIL b2b_done got busy=%b want=0", busy);
        else passed++;
    endtask

    task automatic test_reset_mid();
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        issue(32'h002081B3);
        total++;
        if ({busy, rf_rd_en} !== 2'b11) $display("FAIL rstmid_pre got=%b want=11", {busy, rf_rd_en});
        else passed++;
        rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) @(negedge clk);
        total++;
        if ({busy, wb_valid, instr_ready} !== 3'b001) begin
            $display("FAIL rstmid_after got=%b want=001", {busy, wb_valid, instr_ready});
        end else passed++;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instruction = 32'd0;
        wb_ready    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_ops();
        test_illegal();
        test_rd_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
